gpmc_ctrl_engine: RTL

GPMC_CTRL_ENGINE -- requirements
Module: gpmc_ctrl_engine

---
 rtl/gpmc_ctrl_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gpmc_ctrl_engine.sv
// Command/response control engine: parses 2-beat settings commands,
// issues settings writes or readbacks, and returns a 2-beat response.
// Ports: clk/arst_n/clear, ctrl_* command stream in, resp_* response
// stream out, set_* settings write, rb_* readback, err_count.
module gpmc_ctrl_engine #(
  parameter int SET_AW = 8,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clear,
  input  logic [35:0]       ctrl_data,
  input  logic              ctrl_src_rdy,
  output logic              ctrl_dst_rdy,
  output logic [35:0]       resp_data,
  output logic              resp_src_rdy,
  input  logic              resp_dst_rdy,
  output logic              set_stb,
  output logic [SET_AW-1:0] set_addr,
  output logic [31:0]       set_data,
  output logic [SET_AW-1:0] rb_addr,
  input  logic [31:0]       rb_data,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_ACT,
    S_RSP0,
    S_RSP1,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [15:0]       seq_q;
  logic              rd_q;
  logic [SET_AW-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rsp_q;
  logic [ERR_W-1:0]  err_q;

  logic        sof;
  logic        eof;
  logic        c_xfer;
  logic        r_xfer;
  logic [15:0] addr_w;
  logic        unused_bits;

  assign sof    = ctrl_data[32];
  assign eof    = ctrl_data[33];
  assign addr_w = 16'(addr_q);

  assign unused_bits = ^{ctrl_data, addr_w};

  // Handshakes are forced low while reset or clear is active so no
  // beat can transfer into a state that is being discarded.
  assign ctrl_dst_rdy = arst_n & ~clear &
    ((state == S_HDR) | (state == S_DATA) | (state == S_DRAIN));
  assign resp_src_rdy = ~clear &
    ((state == S_RSP0) | (state == S_RSP1));
  assign set_stb = ~clear & (state == S_ACT) & ~rd_q;

  assign c_xfer = ctrl_src_rdy & ctrl_dst_rdy;
  assign r_xfer = resp_src_rdy & resp_dst_rdy;

  assign set_addr  = addr_q;
  assign set_data  = data_q;
  assign rb_addr   = addr_q;
  assign err_count = err_q;

  function automatic logic [ERR_W-1:0] sat_inc(
    input logic [ERR_W-1:0] v
  );
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_HDR;
      seq_q     <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      err_q     <= '0;
      resp_data <= '0;
    end else if (clear) begin
      state     <= S_HDR;
      seq_q     <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      err_q     <= '0;
      resp_data <= '0;
    end else begin
      unique case (state)
        S_HDR: begin
          if (c_xfer) begin
            if (sof && !eof) begin
              seq_q  <= ctrl_data[31:16];
              rd_q   <= ctrl_data[8];
              addr_q <= ctrl_data[SET_AW-1:0];
              state  <= S_DATA;
            end else begin
              err_q <= sat_inc(err_q);
              // Orphan body beat: skip the rest of its packet.
              if (!sof && !eof) state <= S_DRAIN;
            end
          end
        end
        S_DATA: begin
          if (c_xfer) begin
            if (eof) begin
              data_q <= ctrl_data[31:0];
              state  <= S_ACT;
            end else begin
              err_q <= sat_inc(err_q);
              state <= S_DRAIN;
            end
          end
        end
        S_ACT: begin
          rsp_q     <= rd_q ? rb_data : data_q;
          resp_data <= {4'b0001, seq_q, 7'b0, rd_q, addr_w[7:0]};
          state     <= S_RSP0;
        end
        S_RSP0: begin
          if (r_xfer) begin
            resp_data <= {4'b0010, rsp_q};
            state     <= S_RSP1;
          end
        end
        S_RSP1: begin
          if (r_xfer) begin
            resp_data <= '0;
            state     <= S_HDR;
          end
        end
        S_DRAIN: begin
          if (c_xfer && eof) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
